// File: rtl/ring_mem_requester.sv
// Core-side ring endpoint: queues client read/write requests, injects them while holding the Token,
// and reassembles 128-bit read lines from the RDreturn/RDdest path.
module ring_mem_requester #(
  parameter logic [3:0] NODE_ID   = 4'd1,
  parameter int         REQ_DEPTH = 4,
  parameter int         MAX_BURST = 2,
  parameter int         MAX_RD    = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  RingIn,
  input  logic [3:0]   SlotTypeIn,
  input  logic [3:0]   SourceIn,
  output logic [31:0]  RingOut,
  output logic [3:0]   SlotTypeOut,
  output logic [3:0]   SourceOut,
  input  logic [31:0]  RDreturn,
  input  logic [3:0]   RDdest,
  input  logic         reqValid,
  input  logic         reqWrite,
  input  logic [25:0]  reqAddr,
  input  logic [127:0] reqData,
  output logic         reqReady,
  output logic         rdValid,
  output logic [127:0] rdData,
  output logic         protoErr
);

  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_ADDR  = 4'd2;
  localparam logic [3:0] SLOT_WDATA = 4'd3;
  localparam logic [3:0] SLOT_NULL  = 4'd7;

  localparam int AW = $clog2(REQ_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(2 * MAX_RD + 1);

  typedef enum logic [1:0] {PASS, WDATA, NEXT} state_t;

  state_t         state, state_n;
  logic [BW-1:0]  burst, burst_n;
  logic [1:0]     wc, wc_n;
  logic           pop, issue_rd, hold, inject_addr;

  logic           mem_write [REQ_DEPTH];
  logic [25:0]    mem_addr  [REQ_DEPTH];
  logic [127:0]   mem_data  [REQ_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    cnt;
  logic           empty, full, enq;

  logic [CW-1:0]  rd_out, rd_q;
  logic           credit_ok;

  logic [1:0]     word_cnt;
  logic [95:0]    rd_buf;

  logic           head_write;
  logic [31:0]    head_addr_word, head_word;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(REQ_DEPTH));
  assign head_write     = mem_write[rd_ptr];
  assign head_addr_word = {3'b000, ~head_write, 2'b00, mem_addr[rd_ptr]};
  assign head_word      = mem_data[rd_ptr][{wc, 5'd0} +: 32];

  // Queued reads count against the credit so issue can never overrun MAX_RD.
  assign credit_ok = ((rd_out + rd_q) < CW'(MAX_RD));
  assign reqReady  = (!full || pop) && (reqWrite || credit_ok);
  assign enq       = reqValid && reqReady;

  always_comb begin
    state_n     = state;
    burst_n     = burst;
    wc_n        = wc;
    pop         = 1'b0;
    issue_rd    = 1'b0;
    hold        = 1'b0;
    inject_addr = 1'b0;
    RingOut     = RingIn;
    SlotTypeOut = SlotTypeIn;
    SourceOut   = SourceIn;
    case (state)
      PASS: begin
        if (SlotTypeIn == SLOT_TOKEN && !empty) begin
          inject_addr = 1'b1;
          burst_n     = BW'(1);
        end
      end
      WDATA: begin
        hold        = 1'b1;
        SlotTypeOut = SLOT_WDATA;
        RingOut     = head_word;
        SourceOut   = NODE_ID;
        wc_n        = wc + 2'd1;
        if (wc == 2'd3) begin
          pop     = 1'b1;
          state_n = NEXT;
        end
      end
      NEXT: begin
        hold = 1'b1;
        if (!empty && burst < BW'(MAX_BURST)) begin
          inject_addr = 1'b1;
          burst_n     = burst + BW'(1);
        end else begin
          SlotTypeOut = SLOT_TOKEN;
          RingOut     = '0;
          SourceOut   = '0;
          state_n     = PASS;
        end
      end
      default: state_n = PASS;
    endcase
    if (inject_addr) begin
      SlotTypeOut = SLOT_ADDR;
      RingOut     = head_addr_word;
      SourceOut   = NODE_ID;
      if (head_write) begin
        wc_n    = 2'd0;
        state_n = WDATA;
      end else begin
        pop      = 1'b1;
        issue_rd = 1'b1;
        state_n  = NEXT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PASS;
      burst    <= '0;
      wc       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      rd_out   <= '0;
      rd_q     <= '0;
      protoErr <= 1'b0;
    end else begin
      state  <= state_n;
      burst  <= burst_n;
      wc     <= wc_n;
      cnt    <= cnt + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
      rd_out <= rd_out + {{(CW-1){1'b0}}, issue_rd} - {{(CW-1){1'b0}}, rdValid};
      rd_q   <= rd_q + {{(CW-1){1'b0}}, enq && !reqWrite} - {{(CW-1){1'b0}}, issue_rd};
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      // Slots arriving while the Token is held are dropped, never forwarded.
      if (hold && SlotTypeIn != SLOT_NULL) protoErr <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      mem_write[wr_ptr] <= reqWrite;
      mem_addr[wr_ptr]  <= reqAddr;
      mem_data[wr_ptr]  <= reqData;
    end
  end

  // Words shift in from the top so word0 ends up in rd_buf[31:0] after three arrivals.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt <= '0;
      rd_buf   <= '0;
      rdValid  <= 1'b0;
      rdData   <= '0;
    end else begin
      rdValid <= 1'b0;
      if (RDdest == NODE_ID) begin
        word_cnt <= word_cnt + 2'd1;
        rd_buf   <= {RDreturn, rd_buf[95:32]};
        if (word_cnt == 2'd3) begin
          rdData  <= {RDreturn, rd_buf};
          rdValid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_mem_requester.sv
// Directed bench for ring_mem_requester: idle pass-through, write/read injection, read return,
// burst limit, read credit, protocol error and mid-hold reset.
module tb_ring_mem_requester;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  RingIn;
  logic [3:0]   SlotTypeIn;
  logic [3:0]   SourceIn;
  logic [31:0]  RingOut;
  logic [3:0]   SlotTypeOut;
  logic [3:0]   SourceOut;
  logic [31:0]  RDreturn;
  logic [3:0]   RDdest;
  logic         reqValid;
  logic         reqWrite;
  logic [25:0]  reqAddr;
  logic [127:0] reqData;
  logic         reqReady;
  logic         rdValid;
  logic [127:0] rdData;
  logic         protoErr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ring_mem_requester #(.NODE_ID(4'd1), .REQ_DEPTH(4), .MAX_BURST(2), .MAX_RD(4)) dut (
    .clock(clock), .reset(reset),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .RDreturn(RDreturn), .RDdest(RDdest),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData),
    .reqReady(reqReady), .rdValid(rdValid), .rdData(rdData), .protoErr(protoErr)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ring_in(input logic [3:0] slot, input logic [31:0] dat, input logic [3:0] src);
    SlotTypeIn = slot;
    RingIn     = dat;
    SourceIn   = src;
  endtask

  task automatic ring_chk(input string tag, input logic [3:0] slot, input logic [31:0] dat,
                          input logic [3:0] src);
    #1;
    check({tag, ".slot"}, {124'd0, SlotTypeOut}, {124'd0, slot});
    check({tag, ".data"}, {96'd0, RingOut}, {96'd0, dat});
    check({tag, ".src"}, {124'd0, SourceOut}, {124'd0, src});
  endtask

  task automatic enqueue(input string tag, input logic wr, input logic [25:0] a,
                         input logic [127:0] d, input logic exp_rdy);
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr  = a;
    reqData  = d;
    #1;
    check(tag, {127'd0, reqReady}, {127'd0, exp_rdy});
    step();
    reqValid = 1'b0;
  endtask

  task automatic return_line(input logic [31:0] w0, w1, w2, w3);
    RDdest = 4'd1; RDreturn = w0; step();
    RDreturn = w1; step();
    RDreturn = w2; step();
    check("ret.no_early_valid", {127'd0, rdValid}, 128'd0);
    RDreturn = w3; step();
    RDdest = 4'd0; RDreturn = '0;
  endtask

  initial begin
    reset = 1'b1;
    ring_in(4'd7, 32'd0, 4'd0);
    RDreturn = '0; RDdest = '0;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst.reqReady", {127'd0, reqReady}, {127'd0, 1'b1});
    check("rst.rdValid", {127'd0, rdValid}, 128'd0);
    check("rst.rdData", rdData, 128'd0);
    check("rst.protoErr", {127'd0, protoErr}, 128'd0);

    // Idle ring: everything passes through, Token included.
    ring_in(4'd1, 32'h0000AAAA, 4'd3); ring_chk("idle.token", 4'd1, 32'h0000AAAA, 4'd3); step();
    ring_in(4'd2, 32'h12345678, 4'd5); ring_chk("idle.addr", 4'd2, 32'h12345678, 4'd5); step();
    ring_in(4'd7, 32'h0, 4'd0);        ring_chk("idle.null", 4'd7, 32'h0, 4'd0);
    check("idle.rdValid", {127'd0, rdValid}, 128'd0);
    step();

    // Write: Address, four WriteData words, Token.
    enqueue("wr.rdy", 1'b1, 26'h123, 128'h00000004_00000003_00000002_00000001, 1'b1);
    ring_in(4'd1, 32'h0, 4'd0); ring_chk("wr.addr", 4'd2, 32'h00000123, 4'd1); step();
    ring_in(4'd7, 32'h0, 4'd0);
    ring_chk("wr.d0", 4'd3, 32'd1, 4'd1); step();
    ring_chk("wr.d1", 4'd3, 32'd2, 4'd1); step();
    ring_chk("wr.d2", 4'd3, 32'd3, 4'd1); step();
    ring_chk("wr.d3", 4'd3, 32'd4, 4'd1); step();
    ring_chk("wr.token", 4'd1, 32'd0, 4'd0); step();
    ring_chk("wr.pass", 4'd7, 32'd0, 4'd0);

    // Read at the top address, then its line comes back.
    enqueue("rd.rdy", 1'b0, 26'h3FFFFFF, 128'd0, 1'b1);
    ring_in(4'd1, 32'h0, 4'd0); ring_chk("rd.addr", 4'd2, 32'h13FFFFFF, 4'd1); step();
    ring_in(4'd7, 32'h0, 4'd0); ring_chk("rd.token", 4'd1, 32'd0, 4'd0); step();
    return_line(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
    check("rd.rdValid", {127'd0, rdValid}, {127'd0, 1'b1});
    check("rd.rdData", rdData, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
    step();
    check("rd.pulse_end", {127'd0, rdValid}, 128'd0);

    // Burst limit: three reads, only two per Token hold.
    enqueue("burst.rdy0", 1'b0, 26'h10, 128'd0, 1'b1);
    enqueue("burst.rdy1", 1'b0, 26'h20, 128'd0, 1'b1);
    enqueue("burst.rdy2", 1'b0, 26'h30, 128'd0, 1'b1);
    ring_in(4'd1, 32'h0, 4'd0); ring_chk("burst.a0", 4'd2, 32'h10000010, 4'd1); step();
    ring_in(4'd7, 32'h0, 4'd0); ring_chk("burst.a1", 4'd2, 32'h10000020, 4'd1); step();
    ring_chk("burst.token", 4'd1, 32'd0, 4'd0); step();
    ring_chk("burst.pass", 4'd7, 32'd0, 4'd0);
    ring_in(4'd1, 32'h0, 4'd0); ring_chk("burst.a2", 4'd2, 32'h10000030, 4'd1); step();
    ring_in(4'd7, 32'h0, 4'd0); ring_chk("burst.token2", 4'd1, 32'd0, 4'd0); step();

    // Credit: three outstanding; one more queued fills the budget.
    enqueue("cred.rdy3", 1'b0, 26'h40, 128'd0, 1'b1);
    enqueue("cred.block_q", 1'b0, 26'h44, 128'd0, 1'b0);
    ring_in(4'd1, 32'h0, 4'd0); ring_chk("cred.a3", 4'd2, 32'h10000040, 4'd1); step();
    ring_in(4'd7, 32'h0, 4'd0); step();
    enqueue("cred.block_out", 1'b0, 26'h48, 128'd0, 1'b0);
    enqueue("cred.write_ok", 1'b1, 26'h50, 128'h44444444_33333333_22222222_11111111, 1'b1);
    return_line(32'h1, 32'h2, 32'h3, 32'h4);
    check("cred.ret_valid", {127'd0, rdValid}, {127'd0, 1'b1});
    reqWrite = 1'b0; #1;
    check("cred.still_blocked", {127'd0, reqReady}, 128'd0);
    step();
    check("cred.restored", {127'd0, reqReady}, {127'd0, 1'b1});

    // Protocol error during hold, then reset in the middle of WriteData.
    ring_in(4'd1, 32'h0, 4'd0); ring_chk("err.addr", 4'd2, 32'h00000050, 4'd1); step();
    ring_in(4'd2, 32'h0000DEAD, 4'd4); ring_chk("err.dropped", 4'd3, 32'h11111111, 4'd1); step();
    ring_in(4'd7, 32'h0, 4'd0);
    check("err.protoErr", {127'd0, protoErr}, {127'd0, 1'b1});
    reset = 1'b1; step(); reset = 1'b0;
    ring_chk("rst2.pass", 4'd7, 32'd0, 4'd0);
    check("rst2.protoErr", {127'd0, protoErr}, 128'd0);
    check("rst2.read_ok", {127'd0, reqReady}, {127'd0, 1'b1});
    ring_in(4'd1, 32'h00005555, 4'd2); ring_chk("rst2.empty_token", 4'd1, 32'h00005555, 4'd2);
    step();
    ring_in(4'd7, 32'h0, 4'd0); ring_chk("rst2.after_token", 4'd7, 32'd0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
